// File: rtl/mult8_pkg.sv
// Shared types and helpers for the 8-bit signed shift-add multiplier datapath.
package mult8_pkg;

  localparam int W = 8;

  // Working register {X, A, B}: packing lets the arithmetic right shift
  // be written as a single concatenation across all three fields.
  typedef struct packed {
    logic                x;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
  } work_t;

  // Sign-extend an operand to the 9-bit width used by the adder.
  function automatic logic signed [W:0] sext9(input logic signed [W-1:0] v);
    return {v[W-1], v};
  endfunction

endpackage

// File: rtl/mult8_datapath_add_sub9.sv
// Combinational 9-bit adder/subtractor for the multiplier accumulator.
// Subtraction is performed as a + ~s + 1, sharing the same adder.
module add_sub9
  import mult8_pkg::*;
(
  input  logic signed [W:0] a9,
  input  logic signed [W:0] s9,
  input  logic              sub,
  output logic signed [W:0] res9
);

  logic signed [W:0] s_op;

  assign s_op = sub ? ~s9 : s9;
  assign res9 = a9 + s_op + $signed({{W{1'b0}}, sub});

endmodule

// File: rtl/mult8_datapath.sv
// Register and arithmetic datapath for the 8-bit signed shift-add multiplier.
// Holds X/A/B and executes one controller command per cycle with priority
// Reset > {Clr_XA, Ld_B} > Sub > Add > Shift_En. Add/Sub only change state
// when the multiplier LSB M is set, so a spurious controller Add is harmless.
module mult8_datapath
  import mult8_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr_XA,
  input  logic         Ld_B,
  input  logic         Add,
  input  logic         Sub,
  input  logic         Shift_En,
  input  logic [W-1:0] S,
  output logic         X,
  output logic [W-1:0] Aval,
  output logic [W-1:0] Bval,
  output logic         M
);

  work_t             work_p1;
  logic signed [W:0] sum_p0;
  logic signed [W:0] a_ext_p0;
  logic signed [W:0] s_ext_p0;

  // Stage p0: combinational accumulate of A with the switch operand
  assign a_ext_p0 = sext9(work_p1.a);
  assign s_ext_p0 = sext9($signed(S));

  add_sub9 u_add_sub9 (
    .a9   (a_ext_p0),
    .s9   (s_ext_p0),
    .sub  (Sub),
    .res9 (sum_p0)
  );

  // Stage p1: working register update under the command priority mux
  always_ff @(posedge Clk) begin
    if (Reset) begin
      work_p1 <= '0;
    end else if (Clr_XA || Ld_B) begin
      if (Clr_XA) begin
        work_p1.x <= 1'b0;
        work_p1.a <= '0;
      end
      if (Ld_B) begin
        work_p1.b <= $signed(S);
      end
    end else if (Sub || Add) begin
      // An add/sub with M=0 is a skip but still blocks Shift_En.
      if (work_p1.b[0]) begin
        work_p1.x <= sum_p0[W];
        work_p1.a <= sum_p0[W-1:0];
      end
    end else if (Shift_En) begin
      work_p1 <= {work_p1.x, work_p1.x, work_p1.a, work_p1.b[W-1:1]};
    end
  end

  assign X    = work_p1.x;
  assign Aval = work_p1.a;
  assign Bval = work_p1.b;
  assign M    = work_p1.b[0];

endmodule

// File: tb/tb_mult8_datapath.sv
// Scoreboard bench for mult8_datapath: each driven command pushes the
// expected X/A/B state, which is popped and compared one edge later.
module tb_mult8_datapath;

  logic       Clk = 1'b0;
  logic       Reset, Clr_XA, Ld_B, Add, Sub, Shift_En;
  logic [7:0] S;
  logic       X, M;
  logic [7:0] Aval, Bval;

  typedef struct {
    logic       x;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t       sb_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic       mx;
  logic [7:0] ma, mb;

  mult8_datapath dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clr_XA   (Clr_XA),
    .Ld_B     (Ld_B),
    .Add      (Add),
    .Sub      (Sub),
    .Shift_En (Shift_En),
    .S        (S),
    .X        (X),
    .Aval     (Aval),
    .Bval     (Bval),
    .M        (M)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one command for one cycle; the model computes the next state.
  task automatic step(input logic rst, input logic clr, input logic ld,
                      input logic add, input logic sub, input logic sh,
                      input logic [7:0] s, input string tag);
    int   r;
    exp_t e;
    Reset = rst; Clr_XA = clr; Ld_B = ld; Add = add; Sub = sub; Shift_En = sh; S = s;
    if (rst) begin
      mx = 1'b0; ma = 8'h00; mb = 8'h00;
    end else if (clr || ld) begin
      if (clr) begin mx = 1'b0; ma = 8'h00; end
      if (ld) mb = s;
    end else if (add || sub) begin
      if (mb[0]) begin
        if (sub) r = int'($signed(ma)) - int'($signed(s));
        else     r = int'($signed(ma)) + int'($signed(s));
        mx = r[8];
        ma = r[7:0];
      end
    end else if (sh) begin
      mb = {ma[0], mb[7:1]};
      ma = {mx, ma[7:1]};
    end
    e.x = mx; e.a = ma; e.b = mb;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".queue"}, 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".X"}, {15'd0, X}, {15'd0, e.x});
      check({tag, ".A"}, {8'd0, Aval}, {8'd0, e.a});
      check({tag, ".B"}, {8'd0, Bval}, {8'd0, e.b});
      check({tag, ".M"}, {15'd0, M}, {15'd0, e.b[0]});
    end
  endtask

  // Full multiply: load, 7 (add, shift) pairs, then (sub, shift).
  task automatic multiply(input logic [7:0] mplier, input logic [7:0] mcand);
    int          p;
    logic [15:0] prod;
    step(0, 1, 1, 0, 0, 0, mplier, "load");
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 1, 0, 0, mcand, "add");
      step(0, 0, 0, 0, 0, 1, mcand, "shift");
    end
    step(0, 0, 0, 0, 1, 0, mcand, "sub");
    step(0, 0, 0, 0, 0, 1, mcand, "shift");
    p    = int'($signed(mplier)) * int'($signed(mcand));
    prod = p[15:0];
    check("product", {Aval, Bval}, prod);
    check("product.X", {15'd0, X}, {15'd0, prod[15]});
  endtask

  initial begin
    Reset = 1'b0; Clr_XA = 1'b0; Ld_B = 1'b0; Add = 1'b0; Sub = 1'b0; Shift_En = 1'b0;
    S = 8'h00; mx = 1'b0; ma = 8'h00; mb = 8'h00;
    @(negedge Clk);

    // Reset dominates every other command
    step(1, 1, 1, 1, 0, 1, 8'hFF, "rst0");
    step(1, 1, 1, 1, 0, 1, 8'hFF, "rst1");
    check("rst.X", {15'd0, X}, 16'd0);
    check("rst.AB", {Aval, Bval}, 16'h0000);

    // 7 * -3 = -21, then MSB corner (-128)*(-128)
    multiply(8'h07, 8'hFD);
    check("7x-3", {Aval, Bval}, 16'hFFEB);
    check("7x-3.X", {15'd0, X}, 16'd1);
    multiply(8'h80, 8'h80);
    check("m128sq", {Aval, Bval}, 16'h4000);
    check("m128sq.X", {15'd0, X}, 16'd0);

    // Add with M=0 is a skip
    step(0, 1, 1, 0, 0, 0, 8'h01, "ldB1");
    step(0, 0, 0, 1, 0, 0, 8'h10, "setA10");
    step(0, 0, 1, 0, 0, 0, 8'h02, "ldB2");
    step(0, 0, 0, 1, 0, 1, 8'h55, "addM0");
    check("addM0.A", {8'd0, Aval}, 16'h0010);

    // Shift with X=1, A=0x01, B=0x00 (reach 9-bit -255 via two adds)
    step(0, 1, 1, 0, 0, 0, 8'h01, "ldB1b");
    step(0, 0, 0, 1, 0, 0, 8'h80, "addm128");
    step(0, 0, 0, 1, 0, 0, 8'h81, "addm127");
    step(0, 0, 1, 0, 0, 0, 8'h00, "ldB0");
    step(0, 0, 0, 0, 0, 1, 8'h00, "shX1");
    check("shX1", {X, Aval, Bval[7:1]}, {1'b1, 8'h80, 7'h40});

    // Clear wins over add
    step(0, 1, 1, 0, 0, 0, 8'h01, "ldB1c");
    step(0, 0, 0, 1, 0, 0, 8'h22, "setA22");
    step(0, 1, 0, 1, 0, 0, 8'h33, "clrVsAdd");
    check("clrVsAdd", {7'd0, X, Aval}, 16'h0000);

    // Add wins over shift
    step(0, 0, 0, 1, 0, 0, 8'h10, "setA10b");
    step(0, 0, 0, 1, 0, 1, 8'h05, "addVsSh");
    check("addVsSh", {7'd0, X, Aval}, 16'h0015);
    check("addVsSh.B", {8'd0, Bval}, 16'h0001);

    // Sub outranks add; M=1
    step(0, 0, 0, 1, 1, 0, 8'h03, "subVsAdd");

    // Reset mid-multiply discards partial results
    step(0, 1, 1, 0, 0, 0, 8'h5B, "ldMid");
    step(0, 0, 0, 1, 0, 0, 8'h77, "addMid");
    step(0, 0, 0, 0, 0, 1, 8'h77, "shMid");
    step(1, 0, 0, 0, 0, 0, 8'h77, "rstMid");

    // Assorted products, fixed and random
    multiply(8'h7F, 8'h7F);
    multiply(8'h7F, 8'h80);
    multiply(8'hFF, 8'hFF);
    multiply(8'h00, 8'h9C);
    for (int k = 0; k < 6; k++) begin
      multiply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
